// File: rtl/lemmings_if.sv
// Lemming FSM handshake: the world drives the terrain sensors, the lemming drives its actions.
interface lemmings_if;
  logic walk_left;
  logic walk_right;
  logic aaah;
  logic digging;
  logic bump_left;
  logic bump_right;
  logic ground;
  logic dig;

  modport master (
    output bump_left, bump_right, ground, dig,
    input  walk_left, walk_right, aaah, digging
  );

  modport slave (
    input  bump_left, bump_right, ground, dig,
    output walk_left, walk_right, aaah, digging
  );
endinterface

// File: rtl/lemmings_world.sv
// Terrain model and closed-loop stimulus for a Lemmings walker FSM: a programmable 1-D track,
// the lemming's position, pit falls, digging, exit detection and outcome reporting.
module lemmings_world #(
  parameter int WIDTH      = 16,
  parameter int PIT_DEPTH  = 4,
  parameter int FALL_LIMIT = 20,
  parameter int DIG_CYCLES = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [$clog2(WIDTH)-1:0]  cfg_addr,
  input  logic [1:0]                cfg_data,
  input  logic                      start,
  input  logic [$clog2(WIDTH)-1:0]  start_pos,
  input  logic [$clog2(WIDTH)-1:0]  exit_pos,
  input  logic                      dig_req,
  lemmings_if.master                lem,
  output logic [$clog2(WIDTH)-1:0]  pos,
  output logic [7:0]                fall_cnt,
  output logic                      busy,
  output logic                      exited,
  output logic                      splat,
  output logic                      dig_rej,
  output logic                      proto_err
);
  localparam int PW  = $clog2(WIDTH);
  localparam int DCW = $clog2(DIG_CYCLES + 1);

  localparam logic [1:0] C_FLOOR = 2'b00;
  localparam logic [1:0] C_WALL  = 2'b01;
  localparam logic [1:0] C_PIT   = 2'b10;
  localparam logic [1:0] C_DIG   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 state_reg, state_next;
  logic [WIDTH-1:0][1:0]  cell_reg, cell_next;
  logic [PW-1:0]          pos_reg, exit_reg;
  logic [7:0]             fall_cnt_reg;
  logic [DCW-1:0]         dig_cnt_reg;
  logic                   pend_reg, dig_reg, dig_rej_reg;
  logic                   exited_reg, splat_reg, proto_reg;

  logic          run, at_left, at_right, wall_l, wall_r, pit_here;
  logic [PW-1:0] left_idx, right_idx;
  logic [1:0]    cell_here;
  logic          move_l, move_r, enter_pit, exit_hit;
  logic          fall_step, land, splat_now, dig_done;
  logic          pend_eff, dig_ok, dig_bad, proto_now;
  logic [7:0]    fall_inc;
  logic [31:0]   fall_next32;

  assign run       = (state_reg == S_RUN);
  assign at_left   = (pos_reg == '0);
  assign at_right  = (pos_reg == PW'(WIDTH - 1));
  // Clamp neighbour indices at the track ends so the lookups never leave the array.
  assign left_idx  = at_left  ? pos_reg : pos_reg - PW'(1);
  assign right_idx = at_right ? pos_reg : pos_reg + PW'(1);
  assign cell_here = cell_reg[pos_reg];
  assign wall_l    = at_left  || (cell_reg[left_idx]  == C_WALL);
  assign wall_r    = at_right || (cell_reg[right_idx] == C_WALL);
  assign pit_here  = (cell_here == C_PIT);

  assign exit_hit  = run && (pos_reg == exit_reg) && !pit_here && !lem.digging;
  assign move_l    = run && !pit_here && !exit_hit && lem.walk_left && !wall_l
                     && !lem.aaah && !lem.digging;
  assign move_r    = run && !pit_here && !exit_hit && lem.walk_right && !wall_r
                     && !lem.aaah && !lem.digging;
  assign enter_pit = (move_l && (cell_reg[left_idx]  == C_PIT))
                  || (move_r && (cell_reg[right_idx] == C_PIT));

  assign fall_step   = run && pit_here && lem.aaah;
  assign fall_inc    = (fall_cnt_reg == 8'hFF) ? 8'hFF : fall_cnt_reg + 8'd1;
  assign fall_next32 = {24'd0, fall_cnt_reg} + 32'd1;
  assign land        = fall_step && (fall_next32 >= 32'(PIT_DEPTH));
  assign splat_now   = (fall_next32 > 32'(FALL_LIMIT));

  assign dig_done  = run && lem.digging && (cell_here == C_DIG)
                     && (dig_cnt_reg == DCW'(DIG_CYCLES - 1));
  // A request in this cycle is resolved immediately; the pending bit only carries it
  // across cycles where the lemming cannot dig yet (falling or already digging).
  assign pend_eff  = pend_reg || (run && dig_req);
  assign dig_ok    = pend_eff && !pit_here && (lem.walk_left || lem.walk_right)
                     && (cell_here == C_DIG);
  assign dig_bad   = pend_eff && ((cell_here == C_FLOOR) || (cell_here == C_WALL));

  assign proto_now = run && ((lem.walk_left  && lem.walk_right) ||
                             (lem.walk_left  && lem.aaah)       ||
                             (lem.walk_left  && lem.digging)    ||
                             (lem.walk_right && lem.aaah)       ||
                             (lem.walk_right && lem.digging)    ||
                             (lem.aaah       && lem.digging));

  assign lem.bump_left  = run && wall_l;
  assign lem.bump_right = run && wall_r;
  assign lem.ground     = !(run && pit_here);
  assign lem.dig        = run && dig_reg;

  assign pos       = pos_reg;
  assign fall_cnt  = fall_cnt_reg;
  assign busy      = run;
  assign exited    = exited_reg;
  assign splat     = splat_reg;
  assign dig_rej   = dig_rej_reg;
  assign proto_err = proto_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      logic at_pos;
      logic cfg_hit;
      assign at_pos  = (pos_reg == PW'(gi));
      assign cfg_hit = (state_reg == S_IDLE) && cfg_we && (cfg_addr == PW'(gi));
      assign cell_next[gi] = cfg_hit            ? cfg_data :
                             (at_pos && land)     ? C_FLOOR  :
                             (at_pos && dig_done) ? C_PIT    :
                                                    cell_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if ((land && splat_now) || exit_hit) state_next = S_DONE;
      S_DONE:  if (start) state_next = S_RUN;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cell_reg     <= '0;
      pos_reg      <= '0;
      exit_reg     <= '0;
      fall_cnt_reg <= '0;
      dig_cnt_reg  <= '0;
      pend_reg     <= 1'b0;
      dig_reg      <= 1'b0;
      dig_rej_reg  <= 1'b0;
      exited_reg   <= 1'b0;
      splat_reg    <= 1'b0;
      proto_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cell_reg    <= cell_next;
      dig_reg     <= 1'b0;
      dig_rej_reg <= 1'b0;
      if (start && !run) begin
        pos_reg      <= start_pos;
        exit_reg     <= exit_pos;
        fall_cnt_reg <= '0;
        dig_cnt_reg  <= '0;
        pend_reg     <= 1'b0;
        exited_reg   <= 1'b0;
        splat_reg    <= 1'b0;
        proto_reg    <= 1'b0;
      end else if (run) begin
        if (move_l)      pos_reg <= pos_reg - PW'(1);
        else if (move_r) pos_reg <= pos_reg + PW'(1);

        if (enter_pit || dig_done) fall_cnt_reg <= '0;
        else if (fall_step)        fall_cnt_reg <= fall_inc;

        if (dig_done)
          dig_cnt_reg <= '0;
        else if (lem.digging && (cell_here == C_DIG))
          dig_cnt_reg <= dig_cnt_reg + DCW'(1);

        pend_reg    <= (dig_ok || dig_bad) ? 1'b0 : pend_eff;
        dig_reg     <= dig_ok;
        dig_rej_reg <= dig_bad;

        if (land)      splat_reg  <= splat_now;
        if (exit_hit)  exited_reg <= 1'b1;
        if (proto_now) proto_reg  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lemmings_world.sv
// Directed closed-loop bench: two worlds (pit depth 4 and 25) each driving a reference lemming FSM.
module tb_lemmings_world;
  localparam logic [1:0] FLOOR = 2'b00, WALL = 2'b01, PIT = 2'b10, DIGG = 2'b11;

  typedef enum logic [2:0] {L_WL, L_WR, L_FL, L_FR, L_DL, L_DR} lstate_t;

  logic       clk = 1'b0;
  logic       rst, cfg_we, start, dig_req, lem_rst, lem_dir, inj_aaah;
  logic [3:0] cfg_addr, start_pos, exit_pos;
  logic [1:0] cfg_data;

  logic [3:0] pos      [2];
  logic [7:0] fall_cnt [2];
  logic       busy [2], exited [2], splat [2], dig_rej [2], proto_err [2];
  logic       bl [2], br [2], gr [2], dg [2], wr [2], aa [2], dgg [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_w
      lemmings_if lif ();
      lstate_t ls;

      lemmings_world #(
        .WIDTH(16), .PIT_DEPTH(gi == 0 ? 4 : 25), .FALL_LIMIT(20), .DIG_CYCLES(3)
      ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .start_pos(start_pos), .exit_pos(exit_pos), .dig_req(dig_req),
        .lem(lif), .pos(pos[gi]), .fall_cnt(fall_cnt[gi]), .busy(busy[gi]),
        .exited(exited[gi]), .splat(splat[gi]), .dig_rej(dig_rej[gi]),
        .proto_err(proto_err[gi])
      );

      // Reference Moore lemming: falling beats digging beats bumping.
      always_ff @(posedge clk) begin
        if (lem_rst) ls <= lem_dir ? L_WR : L_WL;
        else begin
          case (ls)
            L_WL: if (!lif.ground) ls <= L_FL; else if (lif.dig) ls <= L_DL;
                  else if (lif.bump_left) ls <= L_WR;
            L_WR: if (!lif.ground) ls <= L_FR; else if (lif.dig) ls <= L_DR;
                  else if (lif.bump_right) ls <= L_WL;
            L_FL: if (lif.ground) ls <= L_WL;
            L_FR: if (lif.ground) ls <= L_WR;
            L_DL: if (!lif.ground) ls <= L_FL;
            L_DR: if (!lif.ground) ls <= L_FR;
            default: ls <= L_WL;
          endcase
        end
      end

      assign lif.walk_left  = (ls == L_WL);
      assign lif.walk_right = (ls == L_WR);
      assign lif.aaah       = (ls == L_FL) || (ls == L_FR) || inj_aaah;
      assign lif.digging    = (ls == L_DL) || (ls == L_DR);

      assign bl[gi]  = lif.bump_left;
      assign br[gi]  = lif.bump_right;
      assign gr[gi]  = lif.ground;
      assign dg[gi]  = lif.dig;
      assign wr[gi]  = lif.walk_right;
      assign aa[gi]  = lif.aaah;
      assign dgg[gi] = lif.digging;
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic dir);
    lem_dir = dir;
    rst = 1'b1; lem_rst = 1'b1;
    tick();
    rst = 1'b0; lem_rst = 1'b0;
  endtask

  task automatic cfg(input logic [3:0] a, input logic [1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic go(input logic [3:0] sp, input logic [3:0] ep);
    start = 1'b1; start_pos = sp; exit_pos = ep;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_bump_left"},  bl[0], 0);
    chk({tag, "_bump_right"}, br[0], 0);
    chk({tag, "_ground"},     gr[0], 1);
    chk({tag, "_dig"},        dg[0], 0);
    chk({tag, "_pos"},        pos[0], 0);
    chk({tag, "_fall_cnt"},   fall_cnt[0], 0);
    chk({tag, "_busy"},       busy[0], 0);
    chk({tag, "_exited"},     exited[0], 0);
    chk({tag, "_splat"},      splat[0], 0);
    chk({tag, "_dig_rej"},    dig_rej[0], 0);
    chk({tag, "_proto_err"},  proto_err[0], 0);
  endtask

  initial begin
    int nfall;
    rst = 1'b1; lem_rst = 1'b1; lem_dir = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; start_pos = '0; exit_pos = 4'd15; dig_req = 1'b0; inj_aaah = 1'b0;
    tick(); tick();
    chk_reset("reset");
    rst = 1'b0; lem_rst = 1'b0;
    $display("reset state checked");

    // Wall bounce; the second wall is written in the same cycle as start.
    do_reset(1'b0);
    cfg(4'd2, WALL);
    cfg_we = 1'b1; cfg_addr = 4'd9; cfg_data = WALL;
    go(4'd5, 4'd15);
    cfg_we = 1'b0;
    chk("wall_busy", busy[0], 1);
    chk("wall_pos5", pos[0], 5);
    chk("wall_bl_at5", bl[0], 0);
    tick(); chk("wall_pos4", pos[0], 4);
    tick(); chk("wall_pos3", pos[0], 3); chk("wall_bl_at3", bl[0], 1);
    tick(); chk("wall_turn_pos", pos[0], 3); chk("wall_turn_wr", wr[0], 1);
    for (int p = 4; p <= 8; p++) begin
      tick(); chk("wall_right_pos", pos[0], p);
    end
    chk("wall_br_at8", br[0], 1);
    $display("wall bounce: pos=%0d bump_right=%0d", pos[0], br[0]);

    // Pit fall (depth 4) and splat (depth 25) run side by side on the same terrain.
    do_reset(1'b1);
    cfg(4'd6, PIT);
    go(4'd4, 4'd15);
    chk("pit_pos4", pos[0], 4);
    tick(); tick();
    chk("pit_pos6", pos[0], 6);
    chk("pit_ground0", gr[0], 0);
    nfall = 0;
    for (int i = 0; i < 12 && gr[0] == 1'b0; i++) begin
      if (aa[0]) nfall++;
      tick();
    end
    chk("pit_fall_cycles", nfall, 4);
    chk("pit_fall_cnt", fall_cnt[0], 4);
    chk("pit_filled_ground", gr[0], 1);
    chk("pit_splat", splat[0], 0);
    chk("pit_busy", busy[0], 1);
    tick(); tick();
    chk("pit_resume_pos", pos[0], 7);
    chk("pit_cnt_hold", fall_cnt[0], 4);
    $display("pit fall: fall_cnt=%0d pos=%0d", fall_cnt[0], pos[0]);
    for (int i = 0; i < 40 && busy[1] == 1'b1; i++) tick();
    chk("splat_busy", busy[1], 0);
    chk("splat_flag", splat[1], 1);
    chk("splat_fall_cnt", fall_cnt[1], 25);
    chk("splat_exited", exited[1], 0);
    chk("splat_done_ground", gr[1], 1);
    $display("splat: splat=%0d fall_cnt=%0d", splat[1], fall_cnt[1]);

    // Dig on a diggable stretch at 7..9.
    do_reset(1'b1);
    cfg(4'd7, DIGG); cfg(4'd8, DIGG); cfg(4'd9, DIGG);
    go(4'd4, 4'd15);
    tick(); tick(); tick();
    chk("dig_pos7", pos[0], 7);
    dig_req = 1'b1;
    tick();
    dig_req = 1'b0;
    chk("dig_pulse", dg[0], 1);
    chk("dig_no_rej", dig_rej[0], 0);
    tick(); chk("dig_pulse_end", dg[0], 0); chk("dig_digging1", dgg[0], 1); chk("dig_pos9", pos[0], 9);
    tick(); chk("dig_digging2", dgg[0], 1); chk("dig_ground2", gr[0], 1);
    tick(); chk("dig_digging3", dgg[0], 1); chk("dig_ground3", gr[0], 1);
    tick(); chk("dig_hole", gr[0], 0); chk("dig_hole_pos", pos[0], 9); chk("dig_fall_clr", fall_cnt[0], 0);
    $display("dig: hole at pos=%0d ground=%0d", pos[0], gr[0]);

    // Dig reject on floor; an IDLE request beforehand must be ignored.
    do_reset(1'b1);
    dig_req = 1'b1; tick(); dig_req = 1'b0;
    go(4'd2, 4'd15);
    chk("rej_idle_ign0", dig_rej[0], 0);
    tick();
    chk("rej_idle_ign1", dig_rej[0], 0);
    chk("rej_pos3", pos[0], 3);
    dig_req = 1'b1; tick(); dig_req = 1'b0;
    chk("rej_pulse", dig_rej[0], 1);
    chk("rej_no_dig", dg[0], 0);
    tick();
    chk("rej_pulse_end", dig_rej[0], 0);
    chk("rej_no_dig2", dg[0], 0);
    chk("rej_walking", wr[0], 1);
    chk("rej_pos5", pos[0], 5);
    $display("dig reject: pos=%0d dig_rej=%0d", pos[0], dig_rej[0]);

    // Exit, then a re-run from DONE with a protocol violation and a mid-walk reset.
    do_reset(1'b1);
    go(4'd10, 4'd12);
    chk("exit_pos10", pos[0], 10);
    tick(); tick();
    chk("exit_pos12", pos[0], 12);
    chk("exit_not_yet", exited[0], 0);
    tick();
    chk("exit_flag", exited[0], 1);
    chk("exit_busy", busy[0], 0);
    chk("exit_pos_hold", pos[0], 12);
    chk("exit_done_br", br[0], 0);
    $display("exit: exited=%0d pos=%0d", exited[0], pos[0]);

    go(4'd3, 4'd15);
    chk("rerun_busy", busy[0], 1);
    chk("rerun_exit_clr", exited[0], 0);
    chk("rerun_pos3", pos[0], 3);
    tick();
    chk("rerun_pos4", pos[0], 4);
    inj_aaah = 1'b1; tick(); inj_aaah = 1'b0;
    chk("proto_err_set", proto_err[0], 1);
    chk("proto_no_move", pos[0], 4);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_reset("midrst");
    $display("mid-walk reset: pos=%0d busy=%0d", pos[0], busy[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
